// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router packet layout, hop-field constants and clog2 helper
package router_pkg;

  // Field MSB positions expressed as DATA_W - <ofs>, so they track any DATA_W >= 32
  localparam int VC_MSB_OFS = 1;
  localparam int DX_MSB_OFS = 2;
  localparam int DY_MSB_OFS = 5;
  localparam int HX_MSB_OFS = 9;
  localparam int HY_MSB_OFS = 13;
  localparam int SX_MSB_OFS = 17;
  localparam int SY_MSB_OFS = 21;
  localparam int PAYLOAD_W  = 32;

  localparam int HOP_W = 4;

  typedef struct packed {
    logic        vc;
    logic [2:0]  dx;
    logic [3:0]  dy;
    logic [3:0]  hx;
    logic [3:0]  hy;
    logic [3:0]  sx;
    logic [3:0]  sy;
    logic [7:0]  rsvd;
    logic [31:0] payload;
  } packet_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// rtl/router_vc_fifo.sv - single-VC synchronous FIFO with modulo-DEPTH pointers and occupancy count
module router_vc_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int PW    = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CNTW  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNTW-1:0]   count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNTW'(1);
      else if (do_pop && !do_push) count <= count - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/router_vc_outbuf.sv
// rtl/router_vc_outbuf.sv - per-VC output buffer with round-robin link arbitration; ROUTER_OUTBUF_HOPSHIFT_EN enables hop shift
module router_vc_outbuf
  import router_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4,
  parameter int DIM    = 0,
  localparam int VCW   = (NUM_VC > 1) ? clog2(NUM_VC) : 1,
  localparam int CNTW  = clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   phase_internal,
  input  logic                   phase_external,
  input  logic                   enq_valid,
  input  logic [VCW-1:0]         enq_vc,
  input  logic [DATA_W-1:0]      enq_data,
  output logic                   enq_ready,
  output logic                   link_so,
  input  logic                   link_ro,
  output logic [DATA_W-1:0]      link_do,
  output logic [NUM_VC-1:0]      full_vec,
  output logic [NUM_VC-1:0]      empty_vec,
  output logic [NUM_VC*CNTW-1:0] occ
);

  localparam int HOP_MSB = (DIM == 1) ? DATA_W - HY_MSB_OFS : DATA_W - HX_MSB_OFS;
`ifdef ROUTER_OUTBUF_HOPSHIFT_EN
  localparam int HOP_SHIFT = 1;
`else
  localparam int HOP_SHIFT = 0;
`endif

  logic [DATA_W-1:0] head [NUM_VC];
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [VCW-1:0]    rr_ptr;
  logic [VCW-1:0]    sel_vc;
  logic              enq_vc_ok;
  logic              enq_full;
  logic              deq;
  logic [DATA_W-1:0] sel_head;
  logic [DATA_W-1:0] shaped;
  int                idx;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    router_vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .wdata (enq_data),
      .head  (head[v]),
      .full  (full_vec[v]),
      .empty (empty_vec[v]),
      .count (occ[v*CNTW +: CNTW])
    );
  end

  // Out-of-range enq_vc never matches, so it reads as full and is refused
  always_comb begin
    enq_vc_ok = 1'b0;
    enq_full  = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (enq_vc == VCW'(v)) begin
        enq_vc_ok = 1'b1;
        enq_full  = full_vec[v];
      end
    end
  end

  assign enq_ready = reset && phase_internal && enq_vc_ok && !enq_full;

  always_comb begin
    push = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push[v] = enq_valid && enq_ready && (enq_vc == VCW'(v));
    end
  end

  // First non-empty VC at or after rr_ptr, cyclically
  always_comb begin
    sel_vc = '0;
    idx    = 0;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_VC;
      if (!empty_vec[idx]) sel_vc = VCW'(idx);
    end
  end

  always_comb begin
    sel_head = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (sel_vc == VCW'(v)) sel_head = head[v];
    end
  end

  always_comb begin
    shaped = sel_head;
    shaped[HOP_MSB -: HOP_W] = sel_head[HOP_MSB -: HOP_W] >> HOP_SHIFT;
  end

  assign link_so = phase_external && !(&empty_vec);
  assign link_do = link_so ? shaped : '0;
  assign deq     = link_so && link_ro;

  always_comb begin
    pop = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pop[v] = deq && (sel_vc == VCW'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (deq) begin
      rr_ptr <= (sel_vc == VCW'(NUM_VC - 1)) ? '0 : sel_vc + VCW'(1);
    end
  end

endmodule

// File: tb/tb_router_vc_outbuf.sv
// tb/tb_router_vc_outbuf.sv - queue-model and directed checks for router_vc_outbuf
module tb_router_vc_outbuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (2 VCs, depth 4)
  logic        reset, pi, pe, ev, ro;
  logic [0:0]  vc;
  logic [63:0] data;
  logic        rdy, so;
  logic [63:0] dout;
  logic [1:0]  fullv, emptyv;
  logic [5:0]  occ;

  // DUT B: 3 VCs, depth 3 (pointer wrap, out-of-range VC)
  logic        b_reset, b_pi, b_pe, b_ev, b_ro;
  logic [1:0]  b_vc;
  logic [63:0] b_data;
  logic        b_rdy, b_so;
  logic [63:0] b_dout;
  logic [2:0]  b_fullv, b_emptyv;
  logic [5:0]  b_occ;

  router_vc_outbuf #(.DATA_W(64), .NUM_VC(2), .DEPTH(4), .DIM(0)) dut_a (
    .clk(clk), .reset(reset), .phase_internal(pi), .phase_external(pe),
    .enq_valid(ev), .enq_vc(vc), .enq_data(data), .enq_ready(rdy),
    .link_so(so), .link_ro(ro), .link_do(dout),
    .full_vec(fullv), .empty_vec(emptyv), .occ(occ)
  );

  router_vc_outbuf #(.DATA_W(64), .NUM_VC(3), .DEPTH(3), .DIM(0)) dut_b (
    .clk(clk), .reset(b_reset), .phase_internal(b_pi), .phase_external(b_pe),
    .enq_valid(b_ev), .enq_vc(b_vc), .enq_data(b_data), .enq_ready(b_rdy),
    .link_so(b_so), .link_ro(b_ro), .link_do(b_dout),
    .full_vec(b_fullv), .empty_vec(b_emptyv), .occ(b_occ)
  );

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of DUT A: one queue per VC plus the round-robin start point
  logic [63:0] mq [2][$];
  int rr = 0;

  function automatic logic [63:0] hop_adj(input logic [63:0] d);
    logic [63:0] r;
    r = d;
`ifdef ROUTER_OUTBUF_HOPSHIFT_EN
    r[55:52] = d[55:52] >> 1;
`endif
    return r;
  endfunction

  function automatic int model_sel();
    for (int k = 0; k < 2; k++) begin
      if (mq[(rr + k) % 2].size() > 0) return (rr + k) % 2;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int s;
    logic [5:0] e_occ;
    logic [1:0] e_full, e_empty;
    if (check_en) begin
      s = model_sel();
      for (int v = 0; v < 2; v++) begin
        e_occ[v*3 +: 3] = 3'(mq[v].size());
        e_full[v]       = (mq[v].size() == 4);
        e_empty[v]      = (mq[v].size() == 0);
      end
      chk("enq_ready", {63'd0, rdy}, {63'd0, reset && pi && (mq[vc].size() < 4)});
      chk("link_so", {63'd0, so}, {63'd0, pe && (s >= 0)});
      chk("link_do", dout, (pe && s >= 0) ? hop_adj(mq[s][0]) : 64'd0);
      chk("occ", {58'd0, occ}, {58'd0, e_occ});
      chk("full_vec", {62'd0, fullv}, {62'd0, e_full});
      chk("empty_vec", {62'd0, emptyv}, {62'd0, e_empty});
    end
  end

  always @(posedge clk) begin
    int s;
    logic do_enq;
    if (!reset) begin
      mq[0].delete();
      mq[1].delete();
      rr = 0;
    end else begin
      s = model_sel();
      do_enq = ev && pi && (mq[vc].size() < 4);
      if (pe && ro && s >= 0) begin
        void'(mq[s].pop_front());
        rr = (s + 1) % 2;
      end
      if (do_enq) mq[vc].push_back(data);
    end
  end

  task automatic drive_a(input logic r, input logic i_pi, input logic i_pe, input logic i_ev,
                         input logic i_vc, input logic [63:0] d, input logic i_ro);
    reset = r; pi = i_pi; pe = i_pe; ev = i_ev; vc = i_vc; data = d; ro = i_ro;
  endtask

  task automatic drive_b(input logic r, input logic i_pi, input logic i_pe, input logic i_ev,
                         input logic [1:0] i_vc, input logic [63:0] d, input logic i_ro);
    b_reset = r; b_pi = i_pi; b_pe = i_pe; b_ev = i_ev; b_vc = i_vc; b_data = d; b_ro = i_ro;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] pkt36, exp36;
  logic [63:0] rr_pkts [4];
  logic [31:0] rr_order [4];
  int nxt, got, cnt;
  logic exp_rdy, push_ok, pop_ok;

  initial begin
    drive_a(0, 0, 0, 0, 0, 64'd0, 0);
    drive_b(0, 0, 0, 0, 2'd0, 64'd0, 0);
    tick();
    tick();
    check_en = 1'b1;

    // Reset state, enq_ready held low while reset is asserted
    drive_a(0, 1, 1, 1, 0, 64'h1234, 1);
    @(negedge clk);
    chk("rst_ready", {63'd0, rdy}, 64'd0);
    chk("rst_so", {63'd0, so}, 64'd0);
    chk("rst_do", dout, 64'd0);
    chk("rst_empty", {62'd0, emptyv}, 64'd3);
    chk("rst_occ", {58'd0, occ}, 64'd0);
    tick();

    // Single packet, hop shift on Hx
    pkt36 = 64'h0030_0000_ABCD_0001;
`ifdef ROUTER_OUTBUF_HOPSHIFT_EN
    exp36 = 64'h0010_0000_ABCD_0001;
`else
    exp36 = 64'h0030_0000_ABCD_0001;
`endif
    drive_a(1, 1, 0, 1, 0, pkt36, 0);
    tick();
    drive_a(1, 0, 1, 0, 0, 64'd0, 1);
    @(negedge clk);
    chk("hop_so", {63'd0, so}, 64'd1);
    chk("hop_do", dout, exp36);
    tick();
    @(negedge clk);
    chk("hop_so_after", {63'd0, so}, 64'd0);
    tick();

    // Round robin: VC0, VC1, VC0, VC1
    drive_a(0, 0, 0, 0, 0, 64'd0, 0);
    tick();
    rr_pkts  = '{64'h11, 64'h21, 64'h12, 64'h22};
    rr_order = '{32'h11, 32'h21, 32'h12, 32'h22};
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 1, 0, 1, 1'(i % 2), rr_pkts[i], 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 0, 1, 0, 0, 64'd0, 1);
      @(negedge clk);
      chk("rr_order", {32'd0, dout[31:0]}, {32'd0, rr_order[i]});
      tick();
    end

    // Fill VC1, then back-pressure
    drive_a(0, 0, 0, 0, 0, 64'd0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 1, 0, 1, 1, {$urandom, $urandom} & 64'hFF00_FFFF_FFFF_FFFF, 0);
      tick();
    end
    drive_a(1, 1, 0, 1, 1, 64'h55, 0);
    @(negedge clk);
    chk("full_occ1", {61'd0, occ[5:3]}, 64'd4);
    chk("full_flag1", {63'd0, fullv[1]}, 64'd1);
    chk("full_ready", {63'd0, rdy}, 64'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive_a(1, 0, 1, 0, 0, 64'd0, 0);
      @(negedge clk);
      chk("bp_so", {63'd0, so}, 64'd1);
      chk("bp_occ1", {61'd0, occ[5:3]}, 64'd4);
      tick();
    end

    // Reset mid-transfer discards buffered packets
    drive_a(0, 0, 0, 0, 0, 64'd0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive_a(1, 1, 0, 1, 0, 64'hA0 + 64'(i), 0);
      tick();
    end
    drive_a(0, 1, 1, 1, 0, 64'hBB, 1);
    @(negedge clk);
    chk("mid_rst_ready", {63'd0, rdy}, 64'd0);
    tick();
    drive_a(1, 0, 1, 0, 0, 64'd0, 1);
    @(negedge clk);
    chk("post_rst_occ", {58'd0, occ}, 64'd0);
    chk("post_rst_so", {63'd0, so}, 64'd0);
    tick();

    // Randomized traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      drive_a(($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
      tick();
    end
    drive_a(1, 0, 0, 0, 0, 64'd0, 0);

    // DUT B: out-of-range VC is refused
    drive_b(0, 0, 0, 0, 2'd0, 64'd0, 0);
    tick();
    drive_b(1, 1, 0, 1, 2'd3, 64'hDEAD, 0);
    @(negedge clk);
    chk("b_badvc_ready", {63'd0, b_rdy}, 64'd0);
    tick();
    drive_b(1, 0, 0, 0, 2'd0, 64'd0, 0);
    @(negedge clk);
    chk("b_badvc_occ", {58'd0, b_occ}, 64'd0);
    chk("b_badvc_empty", {61'd0, b_emptyv}, 64'd7);
    tick();

    // DUT B: 7 packets through VC0 with depth 3
    for (int i = 0; i < 3; i++) begin
      drive_b(1, 1, 0, 1, 2'd0, 64'h1000 + 64'(i), 0);
      tick();
    end
    drive_b(1, 1, 0, 1, 2'd0, 64'h1003, 0);
    @(negedge clk);
    chk("b_full0", {63'd0, b_fullv[0]}, 64'd1);
    chk("b_occ0", {62'd0, b_occ[1:0]}, 64'd3);
    tick();
    nxt = 3; got = 0; cnt = 3;
    for (int c = 0; c < 30 && got < 7; c++) begin
      drive_b(1, 1, 1, (nxt < 7), 2'd0, 64'h1000 + 64'(nxt), 1);
      exp_rdy = (cnt < 3);
      @(negedge clk);
      chk("b_ready", {63'd0, b_rdy}, {63'd0, exp_rdy});
      chk("b_so", {63'd0, b_so}, {63'd0, cnt > 0});
      if (cnt > 0) begin
        chk("b_wrap_order", b_dout, 64'h1000 + 64'(got));
        got++;
      end
      push_ok = b_ev && exp_rdy;
      pop_ok  = (cnt > 0);
      tick();
      if (push_ok) begin
        nxt++;
        cnt++;
      end
      if (pop_ok) cnt--;
    end
    chk("b_drained", 64'(got), 64'd7);
    drive_b(1, 0, 0, 0, 2'd0, 64'd0, 0);
    @(negedge clk);
    chk("b_empty0", {63'd0, b_emptyv[0]}, 64'd1);
    tick();

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
